// File: rtl/axi_write_responder.sv
// AXI4 write-only slave: one burst at a time into a local word memory, B response, burst counter.
// Build option AXI_WR_RANGE_CHECK_EN: beats outside the memory window are dropped and answered with DECERR.
module axi_write_responder #(
  parameter C_S_BASE_ADDR = 32'h30000000,
  parameter int unsigned C_S_AXI_ID_WIDTH = 1,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_MEM_DEPTH = 64
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  output logic [31:0]                     WR_BURST_COUNT,
  output logic [1:0]                      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where VALID and READY are both high;
  // all READY/VALID outputs here are registered and never depend combinationally on inputs.

  localparam int unsigned BYTES   = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned IDX_LSB = $clog2(BYTES);
  localparam int unsigned IDX_W   = $clog2(C_MEM_DEPTH);
  localparam int unsigned AW      = C_S_AXI_ADDR_WIDTH;
  localparam logic [AW-1:0] BASE     = AW'(C_S_BASE_ADDR);
  localparam logic [AW-1:0] STEP     = AW'(BYTES);
  localparam logic [2:0]    NATIVE_SZ = 3'(IDX_LSB);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                      state;
  logic                        awready_r;
  logic                        wready_r;
  logic                        bvalid_r;
  logic [C_S_AXI_ID_WIDTH-1:0] bid_r;
  logic [1:0]                  bresp_r;
  logic [31:0]                 count_r;

  logic [C_S_AXI_ID_WIDTH-1:0] id_q;
  logic [AW-1:0]               addr_q;
  logic [7:0]                  len_q;
  logic [2:0]                  size_q;
  logic [1:0]                  burst_q;
  logic [7:0]                  beat_cnt;
  logic                        err_q;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

  logic              w_fire;
  logic              last_beat;
  logic              burst_ok;
  logic              beat_err;
  logic              mem_we;
  logic [AW-1:0]     offset;
  logic [IDX_W-1:0]  mem_idx;

  assign w_fire    = (state == ST_DATA) && wready_r && S_AXI_WVALID;
  assign last_beat = (beat_cnt == len_q);
  assign burst_ok  = (burst_q == BURST_FIXED) || (burst_q == BURST_INCR);
  assign beat_err  = !burst_ok || (size_q != NATIVE_SZ) || (S_AXI_WLAST != last_beat);
  assign offset    = addr_q - BASE;
  assign mem_idx   = offset[IDX_LSB +: IDX_W];

`ifdef AXI_WR_RANGE_CHECK_EN
  logic decerr_q;
  logic in_range;
  // Unsigned offset also catches addresses below the base: they wrap to a huge value.
  assign in_range = (offset < AW'(C_MEM_DEPTH * BYTES));
  assign mem_we   = w_fire && burst_ok && in_range;
`else
  logic unused_offset_bits;
  assign unused_offset_bits = ^{offset[AW-1:IDX_LSB+IDX_W], offset[IDX_LSB-1:0]};
  assign mem_we = w_fire && burst_ok;
`endif

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state     <= ST_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= '0;
      bresp_r   <= RESP_OKAY;
      count_r   <= 32'd0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= 8'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'b00;
      beat_cnt  <= 8'd0;
      err_q     <= 1'b0;
`ifdef AXI_WR_RANGE_CHECK_EN
      decerr_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          awready_r <= !(awready_r && S_AXI_AWVALID);
          if (awready_r && S_AXI_AWVALID) begin
            id_q     <= S_AXI_AWID;
            addr_q   <= S_AXI_AWADDR;
            len_q    <= S_AXI_AWLEN;
            size_q   <= S_AXI_AWSIZE;
            burst_q  <= S_AXI_AWBURST;
            beat_cnt <= 8'd0;
            err_q    <= 1'b0;
`ifdef AXI_WR_RANGE_CHECK_EN
            decerr_q <= 1'b0;
`endif
            wready_r <= 1'b1;
            state    <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (w_fire) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (beat_err) err_q <= 1'b1;
`ifdef AXI_WR_RANGE_CHECK_EN
            if (!in_range) decerr_q <= 1'b1;
`endif
            if (burst_q == BURST_INCR) addr_q <= addr_q + STEP;
            // The beat count alone ends the burst; a misplaced WLAST only flags an error.
            if (last_beat) begin
              wready_r <= 1'b0;
              state    <= ST_RESP;
            end
          end
        end

        ST_RESP: begin
          // First RESP cycle lets the final beat's error update settle into the flags.
          if (!bvalid_r) begin
            bvalid_r <= 1'b1;
            bid_r    <= id_q;
`ifdef AXI_WR_RANGE_CHECK_EN
            bresp_r  <= decerr_q ? 2'b11 : (err_q ? RESP_SLVERR : RESP_OKAY);
`else
            bresp_r  <= err_q ? RESP_SLVERR : RESP_OKAY;
`endif
          end else if (S_AXI_BREADY) begin
            bvalid_r  <= 1'b0;
            count_r   <= count_r + 32'd1;
            awready_r <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Memory is deliberately outside the reset domain: reset abandons a burst but keeps data.
  always_ff @(posedge S_AXI_ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (S_AXI_WSTRB[b]) mem[mem_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  assign S_AXI_AWREADY  = awready_r;
  assign S_AXI_WREADY   = wready_r;
  assign S_AXI_BVALID   = bvalid_r;
  assign S_AXI_BID      = bid_r;
  assign S_AXI_BRESP    = bresp_r;
  assign WR_BURST_COUNT = count_r;
  assign dbg_state      = state;

endmodule
